// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the instruction-fetch stage.
//   fetch_state_e : fetch FSM states (IDLE, REQ, HOLD, DRAIN)
//   INSTR_W       : instruction / address width
//   PC_INC        : sequential PC step
//   NOP           : empty instruction word
//   word_align()  : clears the byte-offset bits of an address
package mips_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] PC_INC = 32'd4;
    localparam logic [INSTR_W-1:0] NOP    = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] a);
        return {a[INSTR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_pc_reg.sv
// pc_reg: program counter register for the fetch stage.
// Ports:
//   clk, reset : clock, asynchronous active-high reset (pc <= RESET_PC)
//   inc        : advance pc by PC_INC
//   load       : redirect pc to target (takes priority over inc)
//   target     : redirect address, already word-aligned by the caller
//   pc         : current program counter
module pc_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    input  logic        load,
    input  logic [31:0] target,
    output logic [31:0] pc
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= target;
        end else if (inc) begin
            pc <= pc + PC_INC;   // modulo 2^32, wraps silently
        end
    end

endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage, writer side of the IF/ID register.
// Owns the PC, runs a req/ack handshake with instruction memory, loads IF/ID
// with a one-cycle le strobe, holds a fetched word while stalled, and turns
// taken branches into a PC redirect plus a one-cycle clear strobe.
// Ports:
//   clk, reset               : clock, asynchronous active-high reset
//   stall                    : hazard unit forbids loading IF/ID
//   branch_taken/_target     : redirect request (target low bits ignored)
//   imem_req/imem_addr       : fetch request and address (decoded from state)
//   imem_ack/imem_rdata      : memory response
//   le, clear                : IF/ID load / flush strobes
//   instruccionOut, PC4Out   : fetched word and its address + 4
//   pc                       : current fetch PC
//   align_err                : only with IF_FETCH_ALIGN_CHECK_EN; sticky flag
//                              for a branch target with nonzero low bits
// Build option: `define IF_FETCH_ALIGN_CHECK_EN adds align_err.
module if_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        le,
    output logic        clear,
    output logic [31:0] instruccionOut,
    output logic [31:0] PC4Out,
`ifdef IF_FETCH_ALIGN_CHECK_EN
    output logic        align_err,
`endif
    output logic [31:0] pc
);

    fetch_state_e state, state_nx;

    logic        pc_inc;
    logic        pc_load;
    logic        le_nx;
    logic        clear_nx;
    logic        take_mem;     // deliver the memory word straight to IF/ID
    logic        take_hold;    // deliver the word parked during a stall
    logic        cap_hold;
    logic        cap_drain;
    logic [31:0] hold_word;
    logic [31:0] drain_addr;   // address of the access that cannot be aborted
    logic [31:0] target_al;

    assign target_al = word_align(branch_target);

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk    (clk),
        .reset  (reset),
        .inc    (pc_inc),
        .load   (pc_load),
        .target (target_al),
        .pc     (pc)
    );

    // Memory-side outputs are decoded so the address is stable for the
    // whole request without an extra register stage.
    assign imem_req  = (state == ST_REQ) || (state == ST_DRAIN);
    assign imem_addr = (state == ST_DRAIN) ? drain_addr : pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Branch beats stall, stall beats delivery; le and clear are exclusive.
    always_comb begin
        state_nx  = state;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        le_nx     = 1'b0;
        clear_nx  = 1'b0;
        take_mem  = 1'b0;
        take_hold = 1'b0;
        cap_hold  = 1'b0;
        cap_drain = 1'b0;
        case (state)
            ST_IDLE: begin
                state_nx = ST_REQ;
            end
            ST_REQ: begin
                if (branch_taken) begin
                    pc_load  = 1'b1;
                    clear_nx = 1'b1;
                    if (!imem_ack) begin
                        state_nx  = ST_DRAIN;
                        cap_drain = 1'b1;
                    end
                end else if (imem_ack) begin
                    pc_inc = 1'b1;
                    if (stall) begin
                        cap_hold = 1'b1;
                        state_nx = ST_HOLD;
                    end else begin
                        le_nx    = 1'b1;
                        take_mem = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (branch_taken) begin
                    pc_load  = 1'b1;
                    clear_nx = 1'b1;
                    state_nx = ST_REQ;
                end else if (!stall) begin
                    le_nx     = 1'b1;
                    take_hold = 1'b1;
                    state_nx  = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (branch_taken) begin
                    pc_load  = 1'b1;
                    clear_nx = 1'b1;
                end
                if (imem_ack) begin
                    state_nx = ST_REQ;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            le             <= 1'b0;
            clear          <= 1'b0;
            instruccionOut <= NOP;
            PC4Out         <= '0;
        end else begin
            le    <= le_nx;
            clear <= clear_nx;
            if (take_mem) begin
                instruccionOut <= imem_rdata;
                PC4Out         <= pc + PC_INC;
            end else if (take_hold) begin
                // pc already advanced past the held word when it was captured
                instruccionOut <= hold_word;
                PC4Out         <= pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cap_hold) begin
            hold_word <= imem_rdata;
        end
        if (cap_drain) begin
            drain_addr <= pc;
        end
    end

`ifdef IF_FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            align_err <= 1'b0;
        end else if (branch_taken && (branch_target[1:0] != 2'b00)) begin
            align_err <= 1'b1;
        end
    end
`else
    logic unused_target_lo;
    assign unused_target_lo = ^branch_target[1:0];
`endif

endmodule
